transfer_cmd_parser: RTL and testbench

Byte-stream parser for the TRANSFER command of the key-value ledger command path. Consumes framed bytes `<opcode><src key><dst key><amount>` over a valid/ready handshake. Emits one decoded transfer request per frame, held until the ledger update stage accepts it. Replaces the fixed-format, display-only transfer handler with parametrised field widths, error reporting and backpressure.

---
 rtl/transfer_cmd_parser.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_transfer_cmd_parser.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/transfer_cmd_parser.sv
// transfer_cmd_parser
// Byte-stream parser for the ledger TRANSFER command. Frames arrive as
// <opcode><src key><dst key><amount>, big-endian, one byte per accepted beat.
// A decoded request is held on the output until the update stage accepts it.
// Bad opcodes, idle timeouts and self-transfers produce a one-cycle err pulse.
// Optional feature: define TRANSFER_CHKSUM_EN to require a trailing XOR
// checksum byte covering every earlier byte of the frame, opcode included.
module transfer_cmd_parser #(
  parameter int          KEY_BYTES   = 4,
  parameter int          AMT_BYTES   = 4,
  parameter logic [7:0]  OPCODE      = 8'h54,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*KEY_BYTES-1:0] out_src,
  output logic [8*KEY_BYTES-1:0] out_dst,
  output logic [8*AMT_BYTES-1:0] out_amount,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [15:0]            drop_cnt
);

  localparam int KW    = 8 * KEY_BYTES;
  localparam int AW    = 8 * AMT_BYTES;
  localparam int MAXB  = (KEY_BYTES > AMT_BYTES) ? KEY_BYTES : AMT_BYTES;
  // Byte counter only ever holds 0 .. MAXB-1 within a field.
  localparam int CNT_W = (MAXB > 1) ? $clog2(MAXB) : 1;
  // Idle counter only ever holds 0 .. TIMEOUT_CYC-1 before it fires.
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);

  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] AMT_LAST = CNT_W'(AMT_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SRC  = 3'd1;
  localparam logic [2:0] ST_DST  = 3'd2;
  localparam logic [2:0] ST_AMT  = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;

  localparam logic [1:0] ERR_OPCODE  = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_SELF    = 2'd2;
  localparam logic [1:0] ERR_CHKSUM  = 2'd3;

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic [KW-1:0]    src_r;
  logic [KW-1:0]    dst_r;
  logic [AW-1:0]    amt_r;
  logic             out_valid_r;
  logic [KW-1:0]    out_src_r;
  logic [KW-1:0]    out_dst_r;
  logic [AW-1:0]    out_amt_r;
  logic             err_r;
  logic [1:0]       err_code_r;
  logic [15:0]      drop_cnt_r;

  logic [2:0]       state_s;
  logic [CNT_W-1:0] cnt_s;
  logic [TO_W-1:0]  to_cnt_s;
  logic [KW-1:0]    src_s;
  logic [KW-1:0]    dst_s;
  logic [AW-1:0]    amt_s;
  logic             out_valid_s;
  logic             load_s;
  logic             err_s;
  logic [1:0]       err_code_s;
  logic             drop_s;
  logic             acc_s;
  logic             active_s;
  logic             frame_end_s;

`ifdef TRANSFER_CHKSUM_EN
  logic [7:0]       chk_r;
  logic [7:0]       chk_s;
`endif

  // HOLD is the only state that refuses bytes; depends on state only, never on out_ready.
  assign in_ready = rst_n & (state_r != ST_HOLD);
  assign acc_s    = in_valid & in_ready;
  assign active_s = (state_r == ST_SRC) || (state_r == ST_DST) ||
                    (state_r == ST_AMT) || (state_r == ST_CHK);

  assign out_valid  = out_valid_r;
  assign out_src    = out_src_r;
  assign out_dst    = out_dst_r;
  assign out_amount = out_amt_r;
  assign err        = err_r;
  assign err_code   = err_code_r;
  assign drop_cnt   = drop_cnt_r;

  // Next-state, field shifting, error and output-load decisions for one beat.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    to_cnt_s    = to_cnt_r;
    src_s       = src_r;
    dst_s       = dst_r;
    amt_s       = amt_r;
    out_valid_s = out_valid_r;
    load_s      = 1'b0;
    err_s       = 1'b0;
    err_code_s  = err_code_r;
    drop_s      = 1'b0;
    frame_end_s = 1'b0;
`ifdef TRANSFER_CHKSUM_EN
    chk_s       = chk_r;
`endif

    case (state_r)
      ST_IDLE: begin
        cnt_s    = {CNT_W{1'b0}};
        to_cnt_s = {TO_W{1'b0}};
        if (acc_s) begin
          if (in_byte == OPCODE) begin
            state_s = ST_SRC;
            src_s   = {KW{1'b0}};
            dst_s   = {KW{1'b0}};
            amt_s   = {AW{1'b0}};
`ifdef TRANSFER_CHKSUM_EN
            chk_s   = OPCODE;
`endif
          end else begin
            err_s      = 1'b1;
            err_code_s = ERR_OPCODE;
            drop_s     = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SRC: begin
        if (acc_s) begin
          src_s    = (src_r << 8) | KW'(in_byte);
          to_cnt_s = {TO_W{1'b0}};
`ifdef TRANSFER_CHKSUM_EN
          chk_s    = chk_r ^ in_byte;
`endif
          if (cnt_r == KEY_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = ST_DST;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          state_s = ST_SRC;
        end
      end
      ST_DST: begin
        if (acc_s) begin
          dst_s    = (dst_r << 8) | KW'(in_byte);
          to_cnt_s = {TO_W{1'b0}};
`ifdef TRANSFER_CHKSUM_EN
          chk_s    = chk_r ^ in_byte;
`endif
          if (cnt_r == KEY_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = ST_AMT;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          state_s = ST_DST;
        end
      end
      ST_AMT: begin
        if (acc_s) begin
          amt_s    = (amt_r << 8) | AW'(in_byte);
          to_cnt_s = {TO_W{1'b0}};
`ifdef TRANSFER_CHKSUM_EN
          chk_s    = chk_r ^ in_byte;
`endif
          if (cnt_r == AMT_LAST) begin
            cnt_s = {CNT_W{1'b0}};
`ifdef TRANSFER_CHKSUM_EN
            state_s = ST_CHK;
`else
            frame_end_s = 1'b1;
`endif
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          state_s = ST_AMT;
        end
      end
`ifdef TRANSFER_CHKSUM_EN
      ST_CHK: begin
        if (acc_s) begin
          to_cnt_s = {TO_W{1'b0}};
          if (in_byte != chk_r) begin
            // Checksum failure outranks the self-transfer check.
            state_s    = ST_IDLE;
            err_s      = 1'b1;
            err_code_s = ERR_CHKSUM;
          end else begin
            frame_end_s = 1'b1;
          end
        end else begin
          state_s = ST_CHK;
        end
      end
`endif
      ST_HOLD: begin
        to_cnt_s = {TO_W{1'b0}};
        if (out_valid_r && out_ready) begin
          out_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cnt_s       = {CNT_W{1'b0}};
        to_cnt_s    = {TO_W{1'b0}};
        out_valid_s = 1'b0;
      end
    endcase

    // Final frame byte: keys are complete, so a self-transfer can be rejected here.
    if (frame_end_s) begin
      if (src_r == dst_r) begin
        state_s    = ST_IDLE;
        err_s      = 1'b1;
        err_code_s = ERR_SELF;
      end else begin
        state_s     = ST_HOLD;
        out_valid_s = 1'b1;
        load_s      = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end

    // Idle gap inside a frame: abandon the partial frame once the budget is spent.
    if (TO_EN && active_s && !acc_s) begin
      if (to_cnt_r == TO_LAST) begin
        state_s    = ST_IDLE;
        cnt_s      = {CNT_W{1'b0}};
        to_cnt_s   = {TO_W{1'b0}};
        err_s      = 1'b1;
        err_code_s = ERR_TIMEOUT;
      end else begin
        to_cnt_s = to_cnt_r + 1'b1;
      end
    end else begin
      drop_s = drop_s;
    end
  end

  // FSM, counters and in-flight field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      to_cnt_r <= {TO_W{1'b0}};
      src_r    <= {KW{1'b0}};
      dst_r    <= {KW{1'b0}};
      amt_r    <= {AW{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      to_cnt_r <= to_cnt_s;
      src_r    <= src_s;
      dst_r    <= dst_s;
      amt_r    <= amt_s;
    end
  end

`ifdef TRANSFER_CHKSUM_EN
  // Running XOR of the frame bytes seen so far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_r <= 8'h00;
    end else begin
      chk_r <= chk_s;
    end
  end
`endif

  // Registered decoded request; fields keep the last good frame after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_src_r   <= {KW{1'b0}};
      out_dst_r   <= {KW{1'b0}};
      out_amt_r   <= {AW{1'b0}};
    end else begin
      out_valid_r <= out_valid_s;
      if (load_s) begin
        out_src_r <= src_r;
        out_dst_r <= dst_r;
        out_amt_r <= amt_s;
      end
    end
  end

  // Error pulse, its code, and the saturating dropped-byte count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r      <= 1'b0;
      err_code_r <= 2'd0;
      drop_cnt_r <= 16'h0000;
    end else begin
      err_r      <= err_s;
      err_code_r <= err_code_s;
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_transfer_cmd_parser.sv
// Directed bench for transfer_cmd_parser with KEY_BYTES=2, AMT_BYTES=2,
// TIMEOUT_CYC=8. Build with TRANSFER_CHKSUM_EN to cover the checksum byte.
module tb_transfer_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_src;
  logic [15:0] out_dst;
  logic [15:0] out_amount;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] drop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  transfer_cmd_parser #(
    .KEY_BYTES  (2),
    .AMT_BYTES  (2),
    .OPCODE     (8'h54),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .out_dst   (out_dst),
    .out_amount(out_amount),
    .err       (err),
    .err_code  (err_code),
    .drop_cnt  (drop_cnt)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and return #1 after the edge that accepted it.
  task automatic send(input logic [7:0] b);
    logic ok;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int k = 0; k < 40; k++) begin
      ok = in_ready;
      tick();
      if (ok) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!done) check_val("send_timeout", 64'd0, 64'd1);
  endtask

  // Whole frame, with the XOR trailer when the checksum feature is built in.
  task automatic send_frame(input logic [15:0] s, input logic [15:0] d, input logic [15:0] a);
    logic [7:0] bytes [7];
    logic [7:0] x;
    bytes[0] = 8'h54;
    bytes[1] = s[15:8]; bytes[2] = s[7:0];
    bytes[3] = d[15:8]; bytes[4] = d[7:0];
    bytes[5] = a[15:8]; bytes[6] = a[7:0];
    x = 8'h00;
    for (int i = 0; i < 7; i++) begin
      x = x ^ bytes[i];
      send(bytes[i]);
    end
`ifdef TRANSFER_CHKSUM_EN
    send(x);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check_val("rst_in_ready", in_ready, 64'd0);
    check_val("rst_out_valid", out_valid, 64'd0);
    check_val("rst_err", err, 64'd0);
    check_val("rst_drop", drop_cnt, 64'd0);
    check_val("rst_src", out_src, 64'd0);
    rst_n = 1'b1;
    tick();
    check_val("idle_in_ready", in_ready, 64'd1);

    // 1: basic decode, accepted immediately
    send_frame(16'h0001, 16'h0002, 16'h0010);
    check_val("t1_valid", out_valid, 64'd1);
    check_val("t1_src", out_src, 64'h0001);
    check_val("t1_dst", out_dst, 64'h0002);
    check_val("t1_amt", out_amount, 64'h0010);
    check_val("t1_err", err, 64'd0);
    tick();
    check_val("t1_valid_drop", out_valid, 64'd0);
    check_val("t1_ready_back", in_ready, 64'd1);

    // 2: backpressure for 5 cycles, then a second frame
    out_ready = 1'b0;
    send_frame(16'h0001, 16'h0002, 16'h0010);
    for (int c = 0; c < 5; c++) begin
      check_val("t2_hold_valid", out_valid, 64'd1);
      check_val("t2_hold_ready", in_ready, 64'd0);
      check_val("t2_hold_src", out_src, 64'h0001);
      check_val("t2_hold_amt", out_amount, 64'h0010);
      if (c < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    check_val("t2_release", out_valid, 64'd0);
    check_val("t2_idle_ready", in_ready, 64'd1);
    send_frame(16'h1234, 16'h5678, 16'hABCD);
    check_val("t2b_valid", out_valid, 64'd1);
    check_val("t2b_src", out_src, 64'h1234);
    check_val("t2b_dst", out_dst, 64'h5678);
    check_val("t2b_amt", out_amount, 64'hABCD);
    tick();

    // 3: two bad opcodes then a good frame
    send(8'h41);
    check_val("t3_err1", err, 64'd1);
    check_val("t3_code1", err_code, 64'd0);
    send(8'h42);
    check_val("t3_err2", err, 64'd1);
    check_val("t3_code2", err_code, 64'd0);
    check_val("t3_drop", drop_cnt, 64'd2);
    tick();
    check_val("t3_err_clear", err, 64'd0);
    send_frame(16'h00A5, 16'h005A, 16'h0100);
    check_val("t3_valid", out_valid, 64'd1);
    check_val("t3_src", out_src, 64'h00A5);
    check_val("t3_amt", out_amount, 64'h0100);
    tick();

    // 4: self-transfer is discarded
    send_frame(16'h0007, 16'h0007, 16'h0001);
    check_val("t4_err", err, 64'd1);
    check_val("t4_code", err_code, 64'd2);
    check_val("t4_valid", out_valid, 64'd0);
    check_val("t4_src_kept", out_src, 64'h00A5);
    tick();
    check_val("t4_valid_later", out_valid, 64'd0);
    check_val("t4_err_pulse", err, 64'd0);
    check_val("t4_ready", in_ready, 64'd1);

    // 5: idle timeout after two frame bytes
    send(8'h54);
    send(8'h00);
    for (int c = 0; c < 7; c++) begin
      tick();
      check_val("t5_no_err_yet", err, 64'd0);
    end
    tick();
    check_val("t5_err", err, 64'd1);
    check_val("t5_code", err_code, 64'd1);
    check_val("t5_ready", in_ready, 64'd1);
    send_frame(16'h0003, 16'h0004, 16'h0005);
    check_val("t5_valid", out_valid, 64'd1);
    check_val("t5_src", out_src, 64'h0003);
    check_val("t5_dst", out_dst, 64'h0004);
    check_val("t5_amt", out_amount, 64'h0005);
    tick();

`ifdef TRANSFER_CHKSUM_EN
    // 6: explicit trailer byte 47 decodes, trailer 00 is rejected
    send(8'h54); send(8'h00); send(8'h01); send(8'h00);
    send(8'h02); send(8'h00); send(8'h10); send(8'h47);
    check_val("t6_valid", out_valid, 64'd1);
    check_val("t6_src", out_src, 64'h0001);
    tick();
    send(8'h54); send(8'h00); send(8'h01); send(8'h00);
    send(8'h02); send(8'h00); send(8'h10); send(8'h00);
    check_val("t6_bad_err", err, 64'd1);
    check_val("t6_bad_code", err_code, 64'd3);
    check_val("t6_bad_valid", out_valid, 64'd0);
    tick();
    // Bad checksum on a self-transfer reports the checksum
    send(8'h54); send(8'h00); send(8'h07); send(8'h00);
    send(8'h07); send(8'h00); send(8'h01); send(8'h00);
    check_val("t6_prio_code", err_code, 64'd3);
    tick();
`endif

    // Reset mid-frame: outputs clear immediately, no err pulse
    send(8'h54);
    send(8'h00);
    rst_n = 1'b0;
    #2;
    check_val("mr_valid", out_valid, 64'd0);
    check_val("mr_err", err, 64'd0);
    check_val("mr_src", out_src, 64'd0);
    check_val("mr_amt", out_amount, 64'd0);
    check_val("mr_drop", drop_cnt, 64'd0);
    check_val("mr_ready", in_ready, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("mr_err_after", err, 64'd0);
    send_frame(16'h0102, 16'h0304, 16'h0506);
    check_val("mr_valid_after", out_valid, 64'd1);
    check_val("mr_dst_after", out_dst, 64'h0304);
    check_val("mr_amt_after", out_amount, 64'h0506);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
